// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode constants, TX/RX state encodings
// and the frame-length helper used to size the transmitter bit counter.
package uart_pkg;

   localparam int NONE = 0;
   localparam int EVEN = 1;
   localparam int ODD  = 2;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP,
      RX_WAIT_HIGH
   } rx_state_t;

   // Bit periods on the line for one transmitted frame, start bit through last stop bit.
   function automatic int frame_bits(input int word_size, input int parity, input int stop_bits);
      return 1 + word_size + ((parity != NONE) ? 1 : 0) + stop_bits;
   endfunction

endpackage

// File: rtl/uart_cfg_rx.sv
// UART receiver: 2-flop synchroniser, mid-bit sampling FSM and the
// registered word/error outputs that hold until the next completed frame.
module uart_cfg_rx
   import uart_pkg::*;
#(
   parameter int WORD_SIZE   = 8,
   parameter int PULSE_WIDTH = 16,
   parameter int PARITY      = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic [WORD_SIZE-1:0] data_bits_rx,
   output logic                 rx_valid,
   output logic                 parity_err,
   output logic                 frame_err,
   output rx_state_t            state
);

   localparam int CNT_W = $clog2(PULSE_WIDTH);
   localparam int IDX_W = $clog2(WORD_SIZE);
   localparam int HALF  = PULSE_WIDTH / 2;

   logic                 sync1_q, sync2_q;
   logic                 rx_s;
   logic                 sample;

   rx_state_t            state_q, state_d;
   logic [CNT_W-1:0]     cyc_q, cyc_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [WORD_SIZE-1:0] shift_q, shift_d;
   logic                 par_q, par_d;
   logic [WORD_SIZE-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 perr_q, perr_d;
   logic                 ferr_q, ferr_d;

   assign rx_s         = sync2_q;
   assign sample       = (cyc_q == CNT_W'(PULSE_WIDTH - 1));
   assign data_bits_rx = data_q;
   assign rx_valid     = valid_q;
   assign parity_err   = perr_q;
   assign frame_err    = ferr_q;
   assign state        = state_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         state_q <= RX_IDLE;
         cyc_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         data_q  <= '0;
         valid_q <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         sync1_q <= rx;
         sync2_q <= sync1_q;
         state_q <= state_d;
         cyc_q   <= cyc_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
      end
   end

   // The start bit is checked at half a period, so every later sample lands mid-bit.
   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      par_d   = par_q;
      data_d  = data_q;
      valid_d = 1'b0;
      perr_d  = perr_q;
      ferr_d  = ferr_q;
      case (state_q)
         RX_IDLE: begin
            if (!rx_s) begin
               state_d = RX_START;
               cyc_d   = '0;
            end
         end
         RX_START: begin
            if (cyc_q == CNT_W'(HALF - 1)) begin
               cyc_d   = '0;
               idx_d   = '0;
               state_d = rx_s ? RX_IDLE : RX_DATA;
            end else begin
               cyc_d = cyc_q + 1'b1;
            end
         end
         RX_DATA: begin
            if (sample) begin
               cyc_d   = '0;
               shift_d = {rx_s, shift_q[WORD_SIZE-1:1]};
               if (idx_q == IDX_W'(WORD_SIZE - 1)) begin
                  state_d = (PARITY != NONE) ? RX_PARITY : RX_STOP;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               cyc_d = cyc_q + 1'b1;
            end
         end
         RX_PARITY: begin
            if (sample) begin
               cyc_d   = '0;
               par_d   = rx_s;
               state_d = RX_STOP;
            end else begin
               cyc_d = cyc_q + 1'b1;
            end
         end
         RX_STOP: begin
            if (sample) begin
               cyc_d   = '0;
               valid_d = 1'b1;
               data_d  = shift_q;
               perr_d  = (PARITY != NONE) && ((^shift_q) ^ par_q ^ (PARITY == ODD));
               ferr_d  = ~rx_s;
               // A low stop bit means a break: wait for the line to recover before hunting.
               state_d = rx_s ? RX_IDLE : RX_WAIT_HIGH;
            end else begin
               cyc_d = cyc_q + 1'b1;
            end
         end
         RX_WAIT_HIGH: begin
            if (rx_s) state_d = RX_IDLE;
         end
         default: state_d = RX_IDLE;
      endcase
   end

endmodule

// File: rtl/uart_cfg.sv
// Configurable UART top: inline transmitter FSM plus the uart_cfg_rx receiver.
// Both paths share clk/rst and otherwise run independently.
module uart_cfg
   import uart_pkg::*;
#(
   parameter int WORD_SIZE   = 8,
   parameter int PULSE_WIDTH = 16,
   parameter int PARITY      = 0,
   parameter int STOP_BITS   = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 send_valid,
   input  logic [WORD_SIZE-1:0] data_bits_tx,
   output logic                 tx_ready,
   output logic                 tx,
   input  logic                 rx,
   output logic [WORD_SIZE-1:0] data_bits_rx,
   output logic                 rx_valid,
   output logic                 parity_err,
   output logic                 frame_err,
   output tx_state_t            tx_state,
   output rx_state_t            rx_state
);

   localparam int FRAME_BITS = frame_bits(WORD_SIZE, PARITY, STOP_BITS);
   localparam int CNT_W      = $clog2(PULSE_WIDTH);
   localparam int IDX_W      = $clog2(FRAME_BITS);

   if (WORD_SIZE < 5 || WORD_SIZE > 9) begin : g_bad_word_size
      $error("uart_cfg: WORD_SIZE %0d outside 5..9", WORD_SIZE);
   end
   if (PULSE_WIDTH < 4) begin : g_bad_pulse_width
      $error("uart_cfg: PULSE_WIDTH %0d below 4", PULSE_WIDTH);
   end
   if (PARITY < NONE || PARITY > ODD) begin : g_bad_parity
      $error("uart_cfg: PARITY %0d not 0, 1 or 2", PARITY);
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_cfg: STOP_BITS %0d not 1 or 2", STOP_BITS);
   end

   // Handshake: a word transfers on any edge where send_valid and tx_ready are
   // both high; send_valid is ignored while tx_ready is low, and data_bits_tx
   // only needs to be stable on the accepting edge.
   tx_state_t            state_q, state_d;
   logic [CNT_W-1:0]     cyc_q, cyc_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [WORD_SIZE-1:0] shift_q, shift_d;
   logic                 par_q, par_d;
   logic                 tx_q, tx_d;
   logic                 accept;

   assign tx_ready = (state_q == TX_IDLE);
   assign accept   = send_valid & tx_ready;
   assign tx       = tx_q;
   assign tx_state = state_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= TX_IDLE;
         cyc_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
      end
   end

   // idx counts bit periods across the whole frame; the state follows from it.
   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      par_d   = par_q;
      if (state_q == TX_IDLE) begin
         if (accept) begin
            state_d = TX_START;
            cyc_d   = '0;
            idx_d   = '0;
            shift_d = data_bits_tx;
            par_d   = (^data_bits_tx) ^ (PARITY == ODD);
         end
      end else if (cyc_q == CNT_W'(PULSE_WIDTH - 1)) begin
         cyc_d = '0;
         if (state_q == TX_DATA) shift_d = shift_q >> 1;
         if (idx_q == IDX_W'(FRAME_BITS - 1)) begin
            state_d = TX_IDLE;
            idx_d   = '0;
         end else begin
            idx_d = idx_q + 1'b1;
            if (idx_d <= IDX_W'(WORD_SIZE)) begin
               state_d = TX_DATA;
            end else if (PARITY != NONE && idx_d == IDX_W'(WORD_SIZE + 1)) begin
               state_d = TX_PARITY;
            end else begin
               state_d = TX_STOP;
            end
         end
      end else begin
         cyc_d = cyc_q + 1'b1;
      end
   end

   // The line level is registered from the next state so tx is glitch-free.
   always_comb begin
      tx_d = 1'b1;
      case (state_d)
         TX_START:  tx_d = 1'b0;
         TX_DATA:   tx_d = shift_d[0];
         TX_PARITY: tx_d = par_d;
         default:   tx_d = 1'b1;
      endcase
   end

   uart_cfg_rx #(
      .WORD_SIZE   (WORD_SIZE),
      .PULSE_WIDTH (PULSE_WIDTH),
      .PARITY      (PARITY)
   ) u_rx (
      .clk          (clk),
      .rst          (rst),
      .rx           (rx),
      .data_bits_rx (data_bits_rx),
      .rx_valid     (rx_valid),
      .parity_err   (parity_err),
      .frame_err    (frame_err),
      .state        (rx_state)
   );

endmodule

// File: tb/tb_uart_cfg.sv
// Bench for uart_cfg: instance a (even parity, 1 stop, switchable loopback)
// and instance b (odd parity, 2 stops, permanent loopback).
module tb_uart_cfg;
  import uart_pkg::*;

  localparam int PW      = 16;
  localparam int LAT_MAX = (1 + 8 + 1) * PW + PW / 2 + 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // instance a
  logic       a_send_valid;
  logic [7:0] a_data_tx;
  logic       a_tx_ready, a_tx, a_rx;
  logic [7:0] a_data_rx;
  logic       a_rx_valid, a_parity_err, a_frame_err;
  tx_state_t  a_tx_state;
  rx_state_t  a_rx_state;
  logic       loop_a, rx_drv;
  assign a_rx = loop_a ? a_tx : rx_drv;

  // instance b
  logic       b_send_valid;
  logic [7:0] b_data_tx;
  logic       b_tx_ready, b_tx, b_rx;
  logic [7:0] b_data_rx;
  logic       b_rx_valid, b_parity_err, b_frame_err;
  tx_state_t  b_tx_state;
  rx_state_t  b_rx_state;
  assign b_rx = b_tx;

  uart_cfg #(.WORD_SIZE(8), .PULSE_WIDTH(PW), .PARITY(1), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .send_valid(a_send_valid), .data_bits_tx(a_data_tx),
    .tx_ready(a_tx_ready), .tx(a_tx), .rx(a_rx), .data_bits_rx(a_data_rx),
    .rx_valid(a_rx_valid), .parity_err(a_parity_err), .frame_err(a_frame_err),
    .tx_state(a_tx_state), .rx_state(a_rx_state));

  uart_cfg #(.WORD_SIZE(8), .PULSE_WIDTH(PW), .PARITY(2), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .send_valid(b_send_valid), .data_bits_tx(b_data_tx),
    .tx_ready(b_tx_ready), .tx(b_tx), .rx(b_rx), .data_bits_rx(b_data_rx),
    .rx_valid(b_rx_valid), .parity_err(b_parity_err), .frame_err(b_frame_err),
    .tx_state(b_tx_state), .rx_state(b_rx_state));

  // scoreboard state
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic       line_q[$];
  int         a_vcnt = 0;
  int         b_vcnt = 0;
  logic [9:0] b_rec[16];

  always @(posedge clk) begin
    if (a_rx_valid) a_vcnt <= a_vcnt + 1;
    if (b_rx_valid) begin
      b_rec[b_vcnt[3:0]] <= {b_parity_err, b_frame_err, b_data_rx};
      b_vcnt <= b_vcnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // reference model: parity from a ones count, frame as a list of line levels
  function automatic logic parity_bit(input logic [7:0] d, input int mode);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return (mode == EVEN) ? logic'(ones % 2) : logic'((ones + 1) % 2);
  endfunction

  task automatic build_frame(input logic [7:0] d, input int mode, input int stops,
                             input logic par_flip, input logic stop_val);
    line_q.delete();
    line_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) line_q.push_back(d[i]);
    if (mode != NONE) line_q.push_back(parity_bit(d, mode) ^ par_flip);
    line_q.push_back(stop_val);
    for (int s = 1; s < stops; s++) line_q.push_back(1'b1);
  endtask

  // driver: put line_q on rx_drv, one bit period each (entered on a negedge)
  task automatic drive_line();
    foreach (line_q[i]) begin
      rx_drv = line_q[i];
      repeat (PW) @(negedge clk);
    end
  endtask

  // driver + checks: one loopback frame on instance a
  task automatic send_check_a(input logic [7:0] d, input string tag);
    int n, base, first_c;
    build_frame(d, EVEN, 1, 1'b0, 1'b1);
    base = a_vcnt;
    first_c = 0;
    n = 0;
    while (!a_tx_ready && n < 500) begin @(negedge clk); n++; end
    chk({tag, "_ready_before"}, a_tx_ready, 1);
    a_send_valid = 1'b1;
    a_data_tx = d;
    @(posedge clk);
    @(negedge clk);
    a_send_valid = 1'b0;
    for (int c = 1; c <= line_q.size() * PW; c++) begin
      if (c > 1) @(negedge clk);
      chk($sformatf("%s_tx_c%0d", tag, c), a_tx, line_q[(c - 1) / PW]);
      chk($sformatf("%s_busy_c%0d", tag, c), a_tx_ready, 0);
      if (a_rx_valid && first_c == 0) first_c = c;
    end
    @(negedge clk);
    chk({tag, "_ready_after"}, a_tx_ready, 1);
    chk({tag, "_tx_idle"}, a_tx, 1);
    repeat (4) @(negedge clk);
    chk({tag, "_valid_count"}, a_vcnt - base, 1);
    chk({tag, "_latency_ok"}, (first_c > 0 && first_c - 1 <= LAT_MAX), 1);
    chk({tag, "_data"}, a_data_rx, d);
    chk({tag, "_perr"}, a_parity_err, 0);
    chk({tag, "_ferr"}, a_frame_err, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         base, n, low, idle_c;
    bit         saw_start;
    logic [7:0] d;
    logic       flip;
    logic [9:0] rec;
    logic [7:0] exp_w;
    logic [7:0] words[3];
    words = '{8'h00, 8'hFF, 8'h3C};

    // reset state
    rst = 1'b1; loop_a = 1'b1; rx_drv = 1'b1;
    a_send_valid = 1'b0; a_data_tx = '0; b_send_valid = 1'b0; b_data_tx = '0;
    repeat (3) @(negedge clk);
    chk("rst_a_tx", a_tx, 1);
    chk("rst_a_ready", a_tx_ready, 1);
    chk("rst_a_valid", a_rx_valid, 0);
    chk("rst_a_data", a_data_rx, 0);
    chk("rst_a_perr", a_parity_err, 0);
    chk("rst_a_ferr", a_frame_err, 0);
    chk("rst_a_txst", a_tx_state, TX_IDLE);
    chk("rst_a_rxst", a_rx_state, RX_IDLE);
    chk("rst_b_tx", b_tx, 1);
    chk("rst_b_ready", b_tx_ready, 1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // loopback 8'hA1 with exact line waveform
    send_check_a(8'hA1, "lb_a1");

    // 4-cycle glitch on rx
    loop_a = 1'b0; rx_drv = 1'b1;
    repeat (4) @(negedge clk);
    base = a_vcnt; saw_start = 0; idle_c = 0;
    rx_drv = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (a_rx_state == RX_START) saw_start = 1;
    end
    rx_drv = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (a_rx_state == RX_START) saw_start = 1;
      if (saw_start && a_rx_state == RX_IDLE && idle_c == 0) idle_c = c;
    end
    chk("glitch_saw_start", saw_start, 1);
    chk("glitch_idle_in_12", idle_c != 0, 1);
    repeat (20) @(negedge clk);
    chk("glitch_no_valid", a_vcnt - base, 0);
    chk("glitch_data_held", a_data_rx, 8'hA1);

    // 8'h55 with inverted parity
    base = a_vcnt;
    build_frame(8'h55, EVEN, 1, 1'b1, 1'b1);
    drive_line();
    repeat (4) @(negedge clk);
    chk("perr_count", a_vcnt - base, 1);
    chk("perr_data", a_data_rx, 8'h55);
    chk("perr_flag", a_parity_err, 1);
    chk("perr_ferr", a_frame_err, 0);

    // 8'h3C with low stop bit, then a 40-cycle break
    base = a_vcnt;
    build_frame(8'h3C, EVEN, 1, 1'b0, 1'b0);
    drive_line();
    repeat (40) @(negedge clk);
    chk("brk_count", a_vcnt - base, 1);
    chk("brk_data", a_data_rx, 8'h3C);
    chk("brk_ferr", a_frame_err, 1);
    chk("brk_perr", a_parity_err, 0);
    chk("brk_wait_high", a_rx_state, RX_WAIT_HIGH);
    rx_drv = 1'b1;
    repeat (30) @(negedge clk);
    chk("brk_no_more_valid", a_vcnt - base, 1);
    chk("brk_back_idle", a_rx_state, RX_IDLE);
    chk("brk_ferr_held", a_frame_err, 1);

    // random directly driven frames, random parity corruption
    for (int k = 0; k < 4; k++) begin
      d = 8'($urandom_range(0, 255));
      flip = 1'($urandom_range(0, 1));
      base = a_vcnt;
      build_frame(d, EVEN, 1, flip, 1'b1);
      drive_line();
      repeat (4) @(negedge clk);
      chk($sformatf("rnd%0d_count", k), a_vcnt - base, 1);
      chk($sformatf("rnd%0d_data", k), a_data_rx, d);
      chk($sformatf("rnd%0d_perr", k), a_parity_err, flip);
      chk($sformatf("rnd%0d_ferr", k), a_frame_err, 0);
    end

    // random loopback frames
    loop_a = 1'b1;
    for (int k = 0; k < 2; k++) send_check_a(8'($urandom_range(0, 255)), $sformatf("lb_rnd%0d", k));

    // back-to-back on b: odd parity, 2 stop bits, send_valid held
    base = b_vcnt;
    b_send_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      while (!b_tx_ready && n < 400) begin @(negedge clk); n++; end
      chk($sformatf("b2b%0d_ready", i), b_tx_ready, 1);
      if (i > 0) chk($sformatf("b2b%0d_gap", i), n, 0);
      b_data_tx = words[i];
      exp_q.push_back(words[i]);
      build_frame(words[i], ODD, 2, 1'b0, 1'b1);
      @(posedge clk);
      @(negedge clk);
      if (i == 2) b_send_valid = 1'b0;
      low = 0;
      while (!b_tx_ready && low < 400) begin
        if (low < line_q.size() * PW)
          chk($sformatf("b2b%0d_tx_c%0d", i, low + 1), b_tx, line_q[low / PW]);
        low++;
        @(negedge clk);
      end
      chk($sformatf("b2b%0d_busy_len", i), low, 12 * PW);
    end
    repeat (20) @(negedge clk);
    chk("b2b_count", b_vcnt - base, 3);
    for (int i = 0; i < 3; i++) begin
      exp_w = exp_q.pop_front();
      rec = b_rec[(base + i) % 16];
      chk($sformatf("b2b%0d_data", i), rec[7:0], exp_w);
      chk($sformatf("b2b%0d_errs", i), rec[9:8], 0);
    end

    // reset during data bit 3 of loopback 8'hC3
    base = a_vcnt;
    n = 0;
    while (!a_tx_ready && n < 500) begin @(negedge clk); n++; end
    a_send_valid = 1'b1;
    a_data_tx = 8'hC3;
    @(posedge clk);
    @(negedge clk);
    a_send_valid = 1'b0;
    repeat (4 * PW + 6) @(negedge clk);
    chk("abort_in_frame", a_tx_state, TX_DATA);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_tx", a_tx, 1);
    chk("abort_ready", a_tx_ready, 1);
    chk("abort_valid", a_rx_valid, 0);
    chk("abort_data", a_data_rx, 0);
    chk("abort_rxst", a_rx_state, RX_IDLE);
    repeat (250) @(negedge clk);
    chk("abort_no_valid", a_vcnt - base, 0);
    chk("abort_tx_idle", a_tx, 1);
    send_check_a(8'($urandom_range(0, 255)), "recover");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_cfg.md
UART_CFG -- requirements
Module: uart_cfg

Interface
REQ-001 The block SHALL have parameter WORD_SIZE, default 8: data bits per frame, legal range 5..9.
REQ-002 The block SHALL have parameter PULSE_WIDTH, default 16: clk cycles per bit, legal range 4 or more.
REQ-003 The block SHALL have parameter PARITY, default 0: 0 = none, 1 = even, 2 = odd.
REQ-004 The block SHALL have parameter STOP_BITS, default 1: stop bit periods transmitted, 1 or 2.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock. One clock domain. Reset is synchronous and active-high.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-007 The block SHALL have port send_valid, input, 1 bit: request to transmit data_bits_tx.
REQ-008 The block SHALL have port data_bits_tx, input, WORD_SIZE bits: word to transmit.
REQ-009 The block SHALL have port tx_ready, output, 1 bit: high when the transmitter is idle and will accept a request.
REQ-010 The block SHALL have port tx, output, 1 bit: serial line out, idle high.
REQ-011 The block SHALL have port rx, input, 1 bit: asynchronous serial line in.
REQ-012 The block SHALL have port data_bits_rx, output, WORD_SIZE bits: last received word.
REQ-013 The block SHALL have port rx_valid, output, 1 bit: one-cycle pulse when a received frame completes.
REQ-014 The block SHALL have port parity_err, output, 1 bit: parity mismatch, qualified by rx_valid.
REQ-015 The block SHALL have port frame_err, output, 1 bit: stop bit sampled low, qualified by rx_valid.

Function
REQ-016 The TX FSM SHALL have states IDLE, START, DATA, PARITY and STOP. PARITY is skipped when PARITY = 0.
REQ-017 tx_ready SHALL be high only in IDLE.
REQ-018 A request SHALL be accepted only on a clk edge where send_valid and tx_ready are both high. data_bits_tx SHALL be latched on that same edge.
REQ-019 send_valid SHALL be ignored while tx_ready is low.
REQ-020 tx SHALL go low on the cycle after acceptance and SHALL hold each bit for exactly PULSE_WIDTH cycles.
REQ-021 The frame SHALL be sent in this order: start bit 0, data bits LSB first, optional parity bit, then STOP_BITS × PULSE_WIDTH cycles of 1.
REQ-022 The parity bit SHALL be the XOR of the data bits for even parity, and the inverted XOR for odd parity.
REQ-023 tx_ready SHALL rise on the cycle after the last stop cycle. If send_valid is held high, the next frame SHALL start with no idle gap beyond that one cycle.
REQ-024 rx SHALL pass through a 2-flop synchroniser before any use.
REQ-025 The RX FSM SHALL have states IDLE, START, DATA, PARITY, STOP and WAIT_HIGH.
REQ-026 In IDLE, a synchronised 0 SHALL enter START.
REQ-027 START SHALL resample after floor(PULSE_WIDTH/2) cycles. If the sample is 1 (glitch), the FSM SHALL return to IDLE with no outputs changed.
REQ-028 Data, parity and stop bits SHALL each be sampled PULSE_WIDTH cycles after the previous sample, so sampling stays at mid-bit.
REQ-029 Only the first stop bit SHALL be checked. The receiver SHALL accept 1 or more stop bits regardless of the STOP_BITS setting.
REQ-030 On the stop-bit sample, the receiver SHALL in the same cycle:
- pulse rx_valid for one cycle;
- update data_bits_rx;
- update parity_err (forced to 0 when PARITY = 0);
- update frame_err (set if the stop bit sampled 0).
REQ-031 data_bits_rx and both error flags SHALL then hold until the next rx_valid.
REQ-032 After a stop sample of 1, the RX FSM SHALL return to IDLE. After a stop sample of 0, it SHALL enter WAIT_HIGH and stay there until the synchronised rx is 1, so no start bit is detected during a break.
REQ-033 The TX and RX paths SHALL be fully independent and SHALL operate concurrently.
REQ-034 In loopback (tx fed to rx), rx_valid SHALL assert exactly once per frame, within (1 + WORD_SIZE + P + 0.5) × PULSE_WIDTH + 4 cycles of acceptance, where P = 1 when PARITY ≠ 0 and 0 otherwise.

Reset
REQ-035 On a clk edge with rst high, both FSMs SHALL go to IDLE and the outputs SHALL take these values:
- tx = 1, tx_ready = 1;
- rx_valid = 0;
- data_bits_rx = 0, parity_err = 0, frame_err = 0;
- the synchroniser flops = 1.
REQ-036 A reset during any frame SHALL abort that frame. No rx_valid SHALL be issued for the aborted frame, and tx SHALL be 1 on the first cycle with rst low.

Structure
REQ-037 Package uart_pkg SHALL hold:
- the parity mode constants (NONE, EVEN, ODD);
- the tx_state_t and rx_state_t enums;
- a function computing frame length in bits.
REQ-038 The receiver (synchroniser, RX FSM and bit counters) SHALL be a sub-module named uart_cfg_rx. The transmitter SHALL stay inline in uart_cfg.
REQ-039 Illegal parameter values SHALL be caught by elaboration-time assertions.

Verification (WORD_SIZE 8, PULSE_WIDTH 16, PARITY 1 even, STOP_BITS 1, unless stated otherwise)
REQ-040 Loopback, send 8'hA1 -> tx shows 0,1,0,0,0,0,1,0,1, then parity 1, then stop 1. rx_valid fires once, data_bits_rx = 8'hA1, both error flags 0.
REQ-041 Drive rx low for 4 cycles, then high -> no rx_valid, and the RX FSM is back in IDLE within 12 cycles.
REQ-042 Drive a frame for 8'h55 with the parity bit inverted -> rx_valid fires with data_bits_rx = 8'h55 and parity_err = 1.
REQ-043 Drive a frame for 8'h3C with stop bit 0 and hold rx low for 40 cycles -> frame_err = 1, and no further rx_valid until rx returns high and a new start bit arrives.
REQ-044 Hold send_valid high for 8'h00, 8'hFF, 8'h3C, with STOP_BITS 2 and PARITY 2 -> three back-to-back frames, each received correctly with no errors, and tx_ready low for 12 × 16 cycles per frame.
REQ-045 Assert rst for 1 cycle during data bit 3 of a loopback 8'hC3 -> the next cycle shows tx = 1, tx_ready = 1 and rx_valid = 0, and the aborted frame produces no rx_valid.
